seq_detector_param: RTL and testbench

Parametrised, run-time-programmable serial bit-pattern detector, the general form of the fixed 5-bit "10101" detector. It shifts a qualified serial bit stream into a history register and compares the newest bits against a loadable pattern of programmable length. It supports overlapping and non-overlapping detection and keeps a saturating match counter. It sits between a serial source (switch/button-debounced input or shift-out stage) and the board LEDs/7-segment display logic.

---
 rtl/seq_detector_param.sv | 86 ++++++++
 tb/tb_seq_detector_param.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector with overlap control and a
// saturating match counter. Pattern bit 0 is the most recently received bit.
module seq_detector_param #(
    parameter int                PAT_W    = 5,
    parameter logic [PAT_W-1:0]  PAT_INIT = PAT_W'(5'b10101),
    parameter int                CNT_W    = 8,
    localparam int               LEN_W    = $clog2(PAT_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              x,
    input  logic              x_valid,
    input  logic              pat_load,
    input  logic [PAT_W-1:0]  pat_in,
    input  logic [LEN_W-1:0]  len_in,
    input  logic              overlap,
    output logic              z,
    output logic [PAT_W-1:0]  hist,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              cnt_sat
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] fill;

    logic [PAT_W-1:0] hist_n;
    logic [PAT_W-1:0] len_mask;
    logic [LEN_W-1:0] fill_inc;
    logic [LEN_W-1:0] len_clamped;
    logic             match;

    always_comb begin
        len_clamped = len_in;
        if (len_in == '0 || len_in > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end
    end

    assign hist_n   = {hist[PAT_W-2:0], x};
    assign fill_inc = (fill >= LEN_MAX) ? LEN_MAX : fill + LEN_W'(1);

    // Only the newest len bits take part in the compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len));
        end
    end

    // fill gate keeps an all-zero history from matching an all-zero pattern.
    assign match = (fill_inc >= len) &&
                   ((hist_n & len_mask) == (pattern & len_mask));

    always_ff @(posedge clk) begin
        if (reset) begin
            hist      <= '0;
            fill      <= '0;
            z         <= 1'b0;
            match_cnt <= '0;
            pattern   <= PAT_INIT;
            len       <= LEN_MAX;
        end else if (pat_load) begin
            pattern <= pat_in;
            len     <= len_clamped;
            hist    <= '0;
            fill    <= '0;
            z       <= 1'b0;
        end else if (x_valid) begin
            hist <= hist_n;
            fill <= (match && !overlap) ? '0 : fill_inc;
            z    <= match;
            if (match && match_cnt != CNT_MAX) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
        end else begin
            z <= 1'b0;
        end
    end

    assign cnt_sat = (match_cnt == CNT_MAX);

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus random traffic, all
// checked against a bit-queue reference model; a CNT_W=2 copy shares stimulus.
module tb_seq_detector_param;

    localparam int PAT_W = 5;
    localparam int LEN_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             x = 1'b0;
    logic             x_valid = 1'b0;
    logic             pat_load = 1'b0;
    logic [PAT_W-1:0] pat_in = '0;
    logic [LEN_W-1:0] len_in = '0;
    logic             overlap = 1'b1;

    logic             z, z_s;
    logic [PAT_W-1:0] hist, hist_s;
    logic [7:0]       match_cnt;
    logic [1:0]       match_cnt_s;
    logic             cnt_sat, cnt_sat_s;

    int errors = 0;
    int checks = 0;

    seq_detector_param #(.PAT_W(PAT_W), .PAT_INIT(5'b10101), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid),
        .pat_load(pat_load), .pat_in(pat_in), .len_in(len_in), .overlap(overlap),
        .z(z), .hist(hist), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    seq_detector_param #(.PAT_W(PAT_W), .PAT_INIT(5'b10101), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid),
        .pat_load(pat_load), .pat_in(pat_in), .len_in(len_in), .overlap(overlap),
        .z(z_s), .hist(hist_s), .match_cnt(match_cnt_s), .cnt_sat(cnt_sat_s)
    );

    always #5 clk = ~clk;

    // Reference model: every bit received since the last clear, newest last.
    bit         seen[$];
    logic [4:0] m_pat = 5'b10101;
    int         m_len = PAT_W;
    int         m_fresh = 0;
    logic       m_z = 1'b0;
    int         m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit tail_matches();
        if (m_fresh < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (seen[seen.size() - 1 - k] != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [4:0] model_hist();
        logic [4:0] h = '0;
        for (int k = 0; k < PAT_W; k++) begin
            if (k < seen.size()) h[k] = seen[seen.size() - 1 - k];
        end
        return h;
    endfunction

    task automatic model_update();
        if (reset) begin
            seen.delete();
            m_fresh = 0;
            m_pat = 5'b10101;
            m_len = PAT_W;
            m_z = 1'b0;
            m_cnt = 0;
        end else if (pat_load) begin
            m_pat = pat_in;
            m_len = (len_in == 0 || int'(len_in) > PAT_W) ? PAT_W : int'(len_in);
            seen.delete();
            m_fresh = 0;
            m_z = 1'b0;
        end else if (x_valid) begin
            seen.push_back(x);
            if (seen.size() > PAT_W) void'(seen.pop_front());
            m_fresh = (m_fresh + 1 > PAT_W) ? PAT_W : m_fresh + 1;
            m_z = tail_matches();
            if (m_z) begin
                m_cnt++;
                if (!overlap) m_fresh = 0;
            end
        end else begin
            m_z = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("z", 32'(z), 32'(m_z));
        chk("hist", 32'(hist), 32'(model_hist()));
        chk("match_cnt", 32'(match_cnt), 32'((m_cnt > 255) ? 255 : m_cnt));
        chk("cnt_sat", 32'(cnt_sat), 32'(m_cnt >= 255));
        chk("z_w2", 32'(z_s), 32'(m_z));
        chk("match_cnt_w2", 32'(match_cnt_s), 32'((m_cnt > 3) ? 3 : m_cnt));
        chk("cnt_sat_w2", 32'(cnt_sat_s), 32'(m_cnt >= 3));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic drive(input logic rs, input logic ld, input logic xv, input logic xb);
        reset = rs;
        pat_load = ld;
        x_valid = xv;
        x = xb;
        step();
        reset = 1'b0;
        pat_load = 1'b0;
        x_valid = 1'b0;
    endtask

    task automatic bit_in(input logic b);
        drive(1'b0, 1'b0, 1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_load(input logic [4:0] p, input logic [2:0] l);
        pat_in = p;
        len_in = l;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    logic [6:0]  s7;
    logic [6:0]  zv;
    logic [7:0]  cnt_before;
    int          pulses;

    initial begin
        // Reset state
        do_reset();
        chk("rst_hist", 32'(hist), 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);
        chk("rst_z", 32'(z), 32'd0);

        // Overlapping 1010101 on the default pattern
        overlap = 1'b1;
        s7 = 7'b1010101;
        for (int i = 6; i >= 0; i--) begin
            bit_in(s7[i]);
            zv[6-i] = z;
        end
        chk("ovl_zvec", 32'(zv), 32'(7'b1010000));
        chk("ovl_cnt", 32'(match_cnt), 32'd2);
        chk("ovl_hist", 32'(hist), 32'(5'b10101));

        // Non-overlapping: one hit in 7 bits, second after bit 11
        do_reset();
        overlap = 1'b0;
        for (int i = 6; i >= 0; i--) bit_in(s7[i]);
        chk("novl_cnt7", 32'(match_cnt), 32'd1);
        bit_in(1'b0); bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        chk("novl_z11", 32'(z), 32'd1);
        chk("novl_cnt11", 32'(match_cnt), 32'd2);

        // Programmed 3-bit pattern "011", overlapping
        overlap = 1'b1;
        do_load(5'b00011, 3'd3);
        cnt_before = match_cnt;
        chk("load_keeps_cnt", 32'(cnt_before), 32'd2);
        bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        chk("p011_z3", 32'(z), 32'd1);
        bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        chk("p011_z6", 32'(z), 32'd1);
        chk("p011_cnt", 32'(match_cnt), 32'(cnt_before + 8'd2));

        // x_valid gaps do not break a sequence
        do_reset();
        pulses = 0;
        bit_in(1'b1); idle(4); bit_in(1'b0); idle(4); bit_in(1'b1); idle(4);
        bit_in(1'b0);
        bit_in(1'b1);
        pulses += int'(z);
        chk("gap_z", 32'(z), 32'd1);
        chk("gap_cnt", 32'(match_cnt), 32'd1);

        // Saturation of the 2-bit counter with a 1-bit pattern
        do_reset();
        do_load(5'b00001, 3'd1);
        for (int i = 0; i < 5; i++) bit_in(1'b1);
        chk("sat2_cnt", 32'(match_cnt_s), 32'd3);
        chk("sat2_flag", 32'(cnt_sat_s), 32'd1);
        chk("sat2_z", 32'(z_s), 32'd1);

        // Reset mid-sequence discards progress
        do_reset();
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b0);
        do_reset();
        bit_in(1'b1);
        chk("rstmid_z", 32'(z), 32'd0);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        chk("rstmid_z2", 32'(z), 32'd1);
        chk("rstmid_cnt", 32'(match_cnt), 32'd1);

        // len_in=0 and len_in=7 both clamp to full width
        do_load(5'b10101, 3'd0);
        cnt_before = match_cnt;
        bit_in(1'b0); bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        chk("clamp0_cnt", 32'(match_cnt), 32'(cnt_before + 8'd1));
        do_load(5'b00000, 3'd7);
        for (int i = 0; i < 4; i++) bit_in(1'b0);
        chk("clamp7_z4", 32'(z), 32'd0);
        bit_in(1'b0);
        chk("clamp7_z5", 32'(z), 32'd1);

        // Random traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (int'($urandom_range(0, 15)) == 0) overlap = 1'(($urandom) & 1);
            pat_in = 5'($urandom);
            len_in = 3'($urandom_range(0, 7));
            if (r == 0) drive(1'b1, 1'b0, 1'($urandom & 1), 1'($urandom & 1));
            else if (r < 6) drive(1'b0, 1'b1, 1'($urandom & 1), 1'($urandom & 1));
            else drive(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom & 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
